// File: rtl/fifo_flow_ctrl_if.sv
// Handshake, datapath-control and status signals between the flow controller
// and its producer/consumer/datapath neighbours.
interface fifo_flow_ctrl_if #(
    parameter int CNT_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic             flush_req;
    logic             drain_req;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_wen;
    logic             fifo_ren;
    logic             fifo_clear;
    logic [CNT_W-1:0] count;
    logic             drain_done;
    logic             err_sync;

    modport master (
        output in_valid, out_ready, flush_req, drain_req, fifo_full, fifo_empty,
        input  in_ready, out_valid, fifo_wen, fifo_ren, fifo_clear, count,
               drain_done, err_sync
    );

    modport slave (
        input  in_valid, out_ready, flush_req, drain_req, fifo_full, fifo_empty,
        output in_ready, out_valid, fifo_wen, fifo_ren, fifo_clear, count,
               drain_done, err_sync
    );
endinterface

// File: rtl/fifo_flow_ctrl.sv
// Sequencing controller for a parallel-write/parallel-read FIFO datapath:
// handshakes to wen/ren/clear, occupancy tracking, flush/drain, flag cross-check.
module fifo_flow_ctrl #(
    parameter int SIZE      = 16,
    parameter int MEM_SIZE  = 8,
    parameter int PAR_WRITE = 2,
    parameter int PAR_READ  = 4,
    parameter int CNT_W     = $clog2(MEM_SIZE) + 1
) (
    input  logic             clk,
    input  logic             rstn,
    fifo_flow_ctrl_if.slave  bus
);

    if (SIZE < 1 || PAR_WRITE < 1 || PAR_READ < 1 ||
        PAR_WRITE > MEM_SIZE || PAR_READ > MEM_SIZE) begin : g_bad_params
        $error("fifo_flow_ctrl: inconsistent parameters");
    end

    localparam logic [1:0] ST_INIT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_FLUSH = 2'd3;

    localparam logic [CNT_W:0]   PW_X   = (CNT_W+1)'(PAR_WRITE);
    localparam logic [CNT_W:0]   PR_X   = (CNT_W+1)'(PAR_READ);
    localparam logic [CNT_W:0]   MS_X   = (CNT_W+1)'(MEM_SIZE);
    localparam logic [CNT_W-1:0] MS_CNT = CNT_W'(MEM_SIZE);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             err_sync_q, err_sync_d;

    logic             in_ready, out_valid, wfire, rfire, clear, drain_done;
    logic [CNT_W:0]   cnt_x, cnt_next;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        wfire      = 1'b0;
        rfire      = 1'b0;
        clear      = 1'b0;
        drain_done = 1'b0;
        cnt_x      = {1'b0, count_q};
        cnt_next   = cnt_x;

        case (state_q)
            ST_INIT: begin
                clear   = 1'b1;
                count_d = '0;
                state_d = ST_RUN;
            end
            ST_RUN, ST_DRAIN: begin
                // Handshakes are suppressed while reset is asserted so nothing fires mid-reset.
                if (rstn) begin
                    in_ready  = (state_q == ST_RUN) && !bus.flush_req && !bus.drain_req &&
                                (cnt_x + PW_X <= MS_X);
                    out_valid = !bus.flush_req && (cnt_x >= PR_X);
                    wfire     = bus.in_valid && in_ready;
                    rfire     = out_valid && bus.out_ready;
                    cnt_next  = cnt_x + (wfire ? PW_X : '0) - (rfire ? PR_X : '0);
                    count_d   = cnt_next[CNT_W-1:0];
                    if (bus.flush_req) begin
                        state_d = ST_FLUSH;
                    end else if (state_q == ST_RUN) begin
                        if (bus.drain_req) state_d = ST_DRAIN;
                    end else if (cnt_next < PR_X) begin
                        state_d    = ST_FLUSH;
                        drain_done = 1'b1;
                    end
                end
            end
            default: begin
                clear   = 1'b1;
                count_d = '0;
                state_d = ST_RUN;
            end
        endcase

        // A full counter must be matched by the datapath flag one cycle after the write.
        if (state_q == ST_FLUSH) begin
            err_sync_d = 1'b0;
        end else begin
            err_sync_d = err_sync_q ||
                         (wfire && bus.fifo_full) ||
                         (rfire && bus.fifo_empty) ||
                         ((count_q == MS_CNT) && !bus.fifo_full);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= ST_INIT;
            count_q    <= '0;
            err_sync_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            err_sync_q <= err_sync_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid;
    assign bus.fifo_wen   = wfire;
    assign bus.fifo_ren   = rfire;
    assign bus.fifo_clear = clear;
    assign bus.count      = count_q;
    assign bus.drain_done = drain_done;
    assign bus.err_sync   = err_sync_q;

endmodule

// File: tb/tb_fifo_flow_ctrl.sv
// Directed + randomized bench for fifo_flow_ctrl, checked against an occupancy/mode
// reference model evaluated every cycle.
module tb_fifo_flow_ctrl;

    localparam int MEM = 8;
    localparam int PW  = 2;
    localparam int PR  = 4;

    localparam int M_UNKNOWN = 0;
    localparam int M_INIT    = 1;
    localparam int M_RUN     = 2;
    localparam int M_DRAIN   = 3;
    localparam int M_FLUSH   = 4;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    fifo_flow_ctrl_if #(.CNT_W(4)) bus ();

    fifo_flow_ctrl #(
        .SIZE(16), .MEM_SIZE(MEM), .PAR_WRITE(PW), .PAR_READ(PR), .CNT_W(4)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int tests_run = 0;
    int tests_failed = 0;

    int m_mode = M_UNKNOWN;
    int m_occ  = 0;
    bit m_err  = 1'b0;
    bit rst_drv = 1'b0;
    bit force_full = 1'b0;
    bit force_empty = 1'b0;
    int dd_seen = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, compare outputs against the model, advance the model.
    task automatic cyc(input bit iv, input bit ordy, input bit fl, input bit dr);
        bit e_ir, e_ov, e_wf, e_rf, e_cl, e_dd, full, empty, n_err;
        int n_occ, n_mode;
        @(negedge clk);
        full  = force_full  || (m_occ == MEM);
        empty = force_empty || (m_occ == 0);
        bus.in_valid   = iv;
        bus.out_ready  = ordy;
        bus.flush_req  = fl;
        bus.drain_req  = dr;
        bus.fifo_full  = full;
        bus.fifo_empty = empty;
        rstn = rst_drv;
        #1;
        {e_ir, e_ov, e_wf, e_rf, e_cl, e_dd} = '0;
        n_occ  = m_occ;
        n_mode = m_mode;
        case (m_mode)
            M_INIT, M_FLUSH: begin
                e_cl   = 1'b1;
                n_occ  = 0;
                n_mode = M_RUN;
            end
            M_RUN, M_DRAIN: if (rst_drv) begin
                e_ir  = (m_mode == M_RUN) && !fl && !dr && (m_occ + PW <= MEM);
                e_ov  = !fl && (m_occ >= PR);
                e_wf  = iv && e_ir;
                e_rf  = e_ov && ordy;
                n_occ = m_occ + (e_wf ? PW : 0) - (e_rf ? PR : 0);
                if (fl) n_mode = M_FLUSH;
                else if (m_mode == M_RUN) begin
                    if (dr) n_mode = M_DRAIN;
                end else if (n_occ < PR) begin
                    n_mode = M_FLUSH;
                    e_dd   = 1'b1;
                end
            end
            default: ;
        endcase
        n_err = (m_mode == M_FLUSH) ? 1'b0 :
                (m_err || (e_wf && full) || (e_rf && empty) || (m_occ == MEM && !full));
        if (!rst_drv) begin
            n_mode = M_INIT;
            n_occ  = 0;
            n_err  = 1'b0;
        end
        if (m_mode != M_UNKNOWN) begin
            check("in_ready",   32'(bus.in_ready),   32'(e_ir));
            check("out_valid",  32'(bus.out_valid),  32'(e_ov));
            check("fifo_wen",   32'(bus.fifo_wen),   32'(e_wf));
            check("fifo_ren",   32'(bus.fifo_ren),   32'(e_rf));
            check("fifo_clear", 32'(bus.fifo_clear), 32'(e_cl));
            check("drain_done", 32'(bus.drain_done), 32'(e_dd));
            check("count",      32'(bus.count),      32'(m_occ));
            check("err_sync",   32'(bus.err_sync),   32'(m_err));
        end
        if (bus.drain_done === 1'b1) dd_seen++;
        m_mode = n_mode;
        m_occ  = n_occ;
        m_err  = n_err;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.in_valid = 0; bus.out_ready = 0; bus.flush_req = 0; bus.drain_req = 0;
        bus.fifo_full = 0; bus.fifo_empty = 1;

        // Reset held for three cycles, then INIT clear pulse.
        rst_drv = 0;
        repeat (3) cyc(0, 0, 0, 0);
        check("rst_count", 32'(bus.count), 0);
        check("rst_err", 32'(bus.err_sync), 0);
        rst_drv = 1;
        cyc(1, 0, 0, 0);

        // Four back-to-back writes.
        repeat (4) cyc(1, 0, 0, 0);
        check("t2_count8", 32'(bus.count), 8);
        cyc(1, 0, 0, 0);

        // Read to 4, then simultaneous write and read.
        cyc(0, 1, 0, 0);
        check("t3_count4", 32'(bus.count), 4);
        cyc(1, 1, 0, 0);
        check("t3_count2", 32'(bus.count), 2);

        // Flush pulse at count 6.
        repeat (2) cyc(1, 0, 0, 0);
        check("t4_count6", 32'(bus.count), 6);
        cyc(1, 1, 1, 0);
        cyc(0, 0, 0, 0);
        check("t4_count0", 32'(bus.count), 0);

        // Drain from count 6.
        repeat (3) cyc(1, 0, 0, 0);
        dd_seen = 0;
        cyc(1, 1, 0, 1);
        check("t5_count2", 32'(bus.count), 2);
        cyc(1, 1, 0, 1);
        cyc(0, 1, 0, 0);
        check("t5_count0", 32'(bus.count), 0);
        check("t5_dd_once", 32'(dd_seen), 1);

        // Full flag forced during a write, then reset mid-drain.
        force_full = 1;
        cyc(1, 0, 0, 0);
        force_full = 0;
        check("t6_err_set", 32'(bus.err_sync), 1);
        repeat (3) cyc(1, 0, 0, 0);
        check("t6_err_sticky", 32'(bus.err_sync), 1);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        rst_drv = 0;
        cyc(0, 0, 0, 1);
        check("t6_rst_count", 32'(bus.count), 0);
        check("t6_rst_err", 32'(bus.err_sync), 0);
        rst_drv = 1;
        cyc(0, 0, 0, 0);

        // Randomized traffic with occasional flush/drain/reset and flag faults.
        for (int i = 0; i < 600; i++) begin
            force_full  = ($urandom_range(0, 39) == 0);
            force_empty = ($urandom_range(0, 39) == 0);
            rst_drv     = ($urandom_range(0, 99) != 0);
            cyc($urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0,
                $urandom_range(0, 15) == 0, $urandom_range(0, 9) == 0);
        end
        force_full = 0;
        force_empty = 0;
        rst_drv = 1;
        repeat (4) cyc(0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
